// File: rtl/snd_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : snd_cmd_fifo
//  Purpose  : Sound-command mailbox between the main 6809 board and the sound
//             CPU. The decoder's active-low write strobe and the sound CPU's
//             active-low read strobe are both asynchronous to clk. Each one is
//             synchronised, and its rising (trailing) edge is detected. Bytes
//             are queued in a small FIFO and presented first-word-fall-through.
//  Ports    : clk        system clock (>= 8x the 6809 E clock)
//             rst_n      asynchronous active-low reset
//             sndstb     active-low sound write strobe (async)
//             d[7:0]     main CPU data bus
//             snd_rd_n   active-low sound CPU read strobe (async)
//             ovfclr     clears the sticky overflow flag (active high)
//             snd_data   FIFO head byte, 0x00 when empty
//             snd_irq_n  low while the FIFO holds at least one byte
//             sndbusy    high when the FIFO is full
//             sndovf     sticky overflow flag
//  Revision : 1.0  initial release
// ============================================================================
module snd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sndstb,
  input  logic [7:0] d,
  input  logic       snd_rd_n,
  input  logic       ovfclr,
  output logic [7:0] snd_data,
  output logic       snd_irq_n,
  output logic       sndbusy,
  output logic       sndovf
);

  localparam logic [AW:0]   c_full    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
  localparam logic [AW-1:0] c_ptr_one = AW'(1);

  // --------------------------------------------------------------------------
  // Strobe synchronisers. All stages reset to 1 (strobe idle), so a strobe
  // that is already low when reset releases shows up only as a falling edge.
  // That falling edge is ignored, and the strobe then pushes exactly once
  // when it rises.
  // --------------------------------------------------------------------------
  logic r_stb_s1, r_stb_s2, r_stb_s3;
  logic r_rd_s1,  r_rd_s2,  r_rd_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stb_s1 <= 1'b1;
      r_stb_s2 <= 1'b1;
      r_stb_s3 <= 1'b1;
      r_rd_s1  <= 1'b1;
      r_rd_s2  <= 1'b1;
      r_rd_s3  <= 1'b1;
    end else begin
      r_stb_s1 <= sndstb;
      r_stb_s2 <= r_stb_s1;
      r_stb_s3 <= r_stb_s2;
      r_rd_s1  <= snd_rd_n;
      r_rd_s2  <= r_rd_s1;
      r_rd_s3  <= r_rd_s2;
    end
  end

  // Trailing-edge events: one per strobe pulse, whatever its length.
  logic w_push;
  logic w_pop;

  assign w_push = r_stb_s2 & ~r_stb_s3;
  assign w_pop  = r_rd_s2  & ~r_rd_s3;

  // --------------------------------------------------------------------------
  // Data hold register. It follows the bus while the first synchroniser stage
  // reports the strobe low. The byte that is pushed is the bus value on the
  // edge where the strobe is first seen high at s1. That edge is the last one
  // with s1 still low at its input. The data bus is stable there on a 6809
  // write, because it is held through the end of E.
  // --------------------------------------------------------------------------
  logic [7:0] r_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= 8'h00;
    end else if (!r_stb_s1) begin
      r_hold <= d;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO control. Full and empty are taken from the occupancy count only, so
  // the pointers can wrap freely.
  // --------------------------------------------------------------------------
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;
  logic w_ovf_set;

  assign w_full    = (r_count == c_full);
  assign w_empty   = (r_count == '0);
  // A pop on an empty FIFO is simply ignored.
  assign w_do_pop  = w_pop & ~w_empty;
  // When the FIFO is full, a push is still accepted if a pop frees a slot on
  // the same edge. The slot being written is then the old head slot.
  assign w_do_push = w_push & (~w_full | w_do_pop);
  assign w_ovf_set = w_push & w_full & ~w_do_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // If a new overflow and a clear arrive on the same edge, the new overflow
  // takes priority over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (ovfclr) begin
      r_ovf <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Storage. It has no reset: an entry is only visible when the count says it
  // is valid, and an empty FIFO always shows 0x00.
  // --------------------------------------------------------------------------
  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= r_hold;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs are decoded only from registers, so no input reaches an output
  // without first passing through a flop.
  // --------------------------------------------------------------------------
  assign snd_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign snd_irq_n = w_empty;
  assign sndbusy   = w_full;
  assign sndovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_snd_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snd_cmd_fifo
//  Purpose  : Self-checking bench for snd_cmd_fifo. A queue-based reference
//             is checked against the DUT on every falling clock edge. Directed
//             literal checks are added at the points of interest.
//  Revision : 1.0  initial release
// ============================================================================
module tb_snd_cmd_fifo;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       sndstb   = 1'b1;
  logic [7:0] d        = 8'h00;
  logic       snd_rd_n = 1'b1;
  logic       ovfclr   = 1'b0;
  logic [7:0] snd_data;
  logic       snd_irq_n;
  logic       sndbusy;
  logic       sndovf;

  snd_cmd_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sndstb    (sndstb),
    .d         (d),
    .snd_rd_n  (snd_rd_n),
    .ovfclr    (ovfclr),
    .snd_data  (snd_data),
    .snd_irq_n (snd_irq_n),
    .sndbusy   (sndbusy),
    .sndovf    (sndovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Reference model. Rule: a strobe rising edge takes effect on the third
  // clock edge after the first edge that sees it high. The pushed byte is the
  // bus value on that first "high" edge. The model keeps a short history of
  // raw strobe and bus samples and operates on a plain queue.
  // --------------------------------------------------------------------------
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic       sh1 = 1'b1, sh2 = 1'b1, sh3 = 1'b1;
  logic       rh1 = 1'b1, rh2 = 1'b1, rh3 = 1'b1;
  logic [7:0] dh1 = 8'h00, dh2 = 8'h00;

  always @(posedge clk or negedge rst_n) begin : model
    logic push, pop, was_full;
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      sh1 = 1'b1; sh2 = 1'b1; sh3 = 1'b1;
      rh1 = 1'b1; rh2 = 1'b1; rh3 = 1'b1;
      dh1 = 8'h00; dh2 = 8'h00;
    end else begin
      push     = sh2 && !sh3;
      pop      = rh2 && !rh3;
      was_full = (mq.size() == DEPTH);
      if (pop && mq.size() > 0) void'(mq.pop_front());
      if (push && !(was_full && !pop)) mq.push_back(dh2);
      if (push && was_full && !pop) m_ovf = 1'b1;
      else if (ovfclr)              m_ovf = 1'b0;
      sh3 = sh2; sh2 = sh1; sh1 = sndstb;
      rh3 = rh2; rh2 = rh1; rh1 = snd_rd_n;
      dh2 = dh1; dh1 = d;
    end
  end

  always @(negedge clk) begin : compare
    logic [7:0] exp_head;
    exp_head = (mq.size() > 0) ? mq[0] : 8'h00;
    check("model_head",  snd_data, exp_head);
    check("model_irq_n", {7'd0, snd_irq_n}, (mq.size() == 0) ? 8'h01 : 8'h00);
    check("model_busy",  {7'd0, sndbusy},   (mq.size() == DEPTH) ? 8'h01 : 8'h00);
    check("model_ovf",   {7'd0, sndovf},    {7'd0, m_ovf});
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers; inputs change on the falling edge.
  // --------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk); d = b; sndstb = 1'b0;
    idle(2);
    sndstb = 1'b1;
    idle(4);
  endtask

  task automatic read_pulse();
    @(negedge clk); snd_rd_n = 1'b0;
    idle(2);
    snd_rd_n = 1'b1;
    idle(4);
  endtask

  task automatic clear_ovf();
    @(negedge clk); ovfclr = 1'b1;
    @(negedge clk); ovfclr = 1'b0;
  endtask

  logic [7:0] seq_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] seq_b [4] = '{8'hA2, 8'hA3, 8'hA4, 8'h99};

  initial begin
    idle(3);
    check("reset_data",  snd_data, 8'h00);
    check("reset_irq_n", {7'd0, snd_irq_n}, 8'h01);
    check("reset_busy",  {7'd0, sndbusy},   8'h00);
    check("reset_ovf",   {7'd0, sndovf},    8'h00);
    rst_n = 1'b1;
    idle(2);

    // Single push and its latency.
    @(negedge clk); d = 8'h5A; sndstb = 1'b0;
    idle(4);
    sndstb = 1'b1;
    idle(2);
    check("lat_edge2_irq_n", {7'd0, snd_irq_n}, 8'h01);
    idle(1);
    check("lat_edge3_data",  snd_data, 8'h5A);
    check("lat_edge3_irq_n", {7'd0, snd_irq_n}, 8'h00);
    check("lat_edge3_busy",  {7'd0, sndbusy},   8'h00);
    read_pulse();
    check("drain1_irq_n", {7'd0, snd_irq_n}, 8'h01);

    // Fill, overflow, then drain in order.
    for (int i = 0; i < 4; i++) push_byte(seq_a[i]);
    check("full_busy", {7'd0, sndbusy}, 8'h01);
    push_byte(8'h55);
    check("ovf_set",  {7'd0, sndovf}, 8'h01);
    check("ovf_head", snd_data, 8'h11);
    for (int i = 0; i < 4; i++) begin
      check("drain_order", snd_data, seq_a[i]);
      read_pulse();
    end
    check("empty_irq_n", {7'd0, snd_irq_n}, 8'h01);
    check("empty_data",  snd_data, 8'h00);
    clear_ovf();
    check("ovf_cleared", {7'd0, sndovf}, 8'h00);

    // Simultaneous push and pop while full.
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3); push_byte(8'hA4);
    @(negedge clk); d = 8'h99; sndstb = 1'b0; snd_rd_n = 1'b0;
    idle(2);
    sndstb = 1'b1; snd_rd_n = 1'b1;
    idle(5);
    check("simul_ovf",  {7'd0, sndovf},  8'h00);
    check("simul_busy", {7'd0, sndbusy}, 8'h01);
    for (int i = 0; i < 4; i++) begin
      check("simul_order", snd_data, seq_b[i]);
      read_pulse();
    end
    check("simul_empty", {7'd0, snd_irq_n}, 8'h01);

    // Reads while empty are ignored.
    read_pulse(); read_pulse();
    check("underflow_irq_n", {7'd0, snd_irq_n}, 8'h01);
    check("underflow_data",  snd_data, 8'h00);
    check("underflow_busy",  {7'd0, sndbusy}, 8'h00);

    // Overflow, clear, then clear coinciding with a new overflow.
    push_byte(8'hB1); push_byte(8'hB2); push_byte(8'hB3); push_byte(8'hB4);
    push_byte(8'hB5);
    check("ovf2_set", {7'd0, sndovf}, 8'h01);
    clear_ovf();
    check("ovf2_clr", {7'd0, sndovf}, 8'h00);
    @(negedge clk); d = 8'hC5; sndstb = 1'b0;
    idle(2);
    sndstb = 1'b1;
    idle(2);
    ovfclr = 1'b1;
    idle(1);
    ovfclr = 1'b0;
    check("ovf_set_wins", {7'd0, sndovf}, 8'h01);
    check("ovf_set_head", snd_data, 8'hB1);
    clear_ovf();
    for (int i = 0; i < 4; i++) read_pulse();
    check("ovf_drained", {7'd0, snd_irq_n}, 8'h01);

    // A long pulse with the bus changing mid-pulse gives one push.
    @(negedge clk); d = 8'h01; sndstb = 1'b0;
    idle(10);
    d = 8'h02;
    idle(10);
    sndstb = 1'b1;
    idle(5);
    check("long_data",  snd_data, 8'h02);
    check("long_irq_n", {7'd0, snd_irq_n}, 8'h00);
    read_pulse();
    check("long_single", {7'd0, snd_irq_n}, 8'h01);

    // Reset in the middle of a strobe.
    push_byte(8'h61); push_byte(8'h62);
    @(negedge clk); d = 8'h77; sndstb = 1'b0;
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_data",  snd_data, 8'h00);
    check("midrst_irq_n", {7'd0, snd_irq_n}, 8'h01);
    check("midrst_busy",  {7'd0, sndbusy},   8'h00);
    check("midrst_ovf",   {7'd0, sndovf},    8'h00);
    idle(2);
    d = 8'h88; rst_n = 1'b1;
    idle(3);
    sndstb = 1'b1;
    idle(5);
    check("postrst_data",  snd_data, 8'h88);
    check("postrst_irq_n", {7'd0, snd_irq_n}, 8'h00);
    read_pulse();
    check("postrst_single", {7'd0, snd_irq_n}, 8'h01);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
